booth_r4_mul_seq: RTL and testbench
===================================

Name: booth_r4_mul_seq

Overview:
- Parametrised, handshaked successor of the team's fixed 8-bit radix-4 Booth multiplier.
- Accepts operands of any even WIDTH over a valid/ready interface.
- Supports signed and unsigned mode per transaction.
- Retires one radix-4 digit per clock (add and 2-bit arithmetic shift in the same cycle).
- Presents the full 2*WIDTH product in one beat on a valid/ready output held until consumed; replaces the serial OUTPUT_A/OUTPUT_Q bus readout.

Parameters:
- WIDTH, 8, operand width; must be even and >= 4. Elaboration error otherwise.
- ITER, (WIDTH+2)/2, derived localparam: radix-4 iterations per multiply. Not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept operands.
- multiplicand  in  WIDTH  M operand.
- multiplier  in  WIDTH  Q operand.
- signed_mode  in  1  1 = both operands two's complement; 0 = both unsigned. Sampled with the operands.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*WIDTH  M*Q, exact (no truncation in either mode).
- busy  out  1  high in CALC and DONE.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; in_ready=1, out_valid=0, busy=0, product=0; A, Q, qm, iteration counter cleared. Reset takes effect from any state, including mid-CALC or DONE; the in-flight result is discarded with no output beat.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - Mx = multiplicand extended to WIDTH+2 bits (sign-extend if signed_mode, else zero-extend).
    - Qx = multiplier extended the same way.
    - A = 0 (WIDTH+3 bits); qm = 0; cnt = 0.
  - Next state CALC.
- CALC, one iteration per cycle:
  - Digit from {Qx[1],Qx[0],qm}:
    - 000/111 -> 0
    - 001/010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101/110 -> -M
  - -M/-2M are formed by inverted operand plus carry-in 1.
  - The partial product is sign-extended to WIDTH+3 bits and added to A.
  - {A,Qx,qm} is then arithmetic-shifted right by 2 (A MSB replicated).
  - cnt++. When cnt == ITER-1 at the edge, next state DONE.
- DONE:
  - product register = low 2*WIDTH bits of {A,Qx} after the final shift; out_valid=1.
  - product and out_valid hold stable until out_ready.
  - out_valid&&out_ready -> IDLE at that edge; out_valid drops the next cycle.
- Latency:
  - Accept edge t0. out_valid is high after edge t0+ITER.
  - WIDTH=8: 5 cycles; WIDTH=16: 9 cycles.
  - Minimum issue interval is ITER+2 cycles with out_ready held high.
- in_ready is 0 in CALC and DONE. Operands presented then are ignored, not queued.
- Operand inputs and signed_mode are ignored outside the accept cycle. Changing them mid-CALC has no effect.
- out_ready outside DONE is ignored.
- Extreme cases:
  - Unsigned max*max and signed min*min are exact.
  - Multiplier 0 still takes the full ITER cycles (no early termination).

Decomposition:
- Package booth_pkg: state_t enum {IDLE, CALC, DONE}; booth_digit_t enum {D_ZERO, D_P1, D_P2, D_M1, D_M2}; function iter_count(width) returning (width+2)/2.
- Sub-module booth_r4_recoder: combinational; inputs 3-bit window and Mx; outputs booth_digit_t plus the WIDTH+3-bit addend and carry-in.
- The top holds the FSM, datapath registers and handshake.

Test Plan:
- WIDTH=8, signed, M=-3 (8'hFD), Q=7, out_ready=1 -> out_valid 5 cycles after accept, product=16'hFFEB; in_ready low throughout CALC/DONE.
- WIDTH=8, unsigned, M=8'hFF, Q=8'hFF -> product=16'hFE01. Same operands signed -> 16'h0001.
- WIDTH=8, signed, M=8'h80, Q=8'h80 -> 16'h4000; M=8'h80, Q=8'h7F -> 16'hC080; M=0x5A, Q=0 -> 16'h0000 after the full 5 cycles.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product and out_valid stable, in_ready=0, new in_valid ignored. Then out_ready=1 -> IDLE next edge; a following operand pair is accepted.
- Reset mid-op: rst_n low at iteration 2 -> next edge out_valid=0, product=0, in_ready=1. Next multiply (-5*-6) yields 16'h001E correctly.
- WIDTH=16 instance, 500 random signed/unsigned pairs with random in_valid/out_ready gaps -> every product matches reference M*Q; latency exactly 9 cycles.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      D_ZERO = 3'd0,
      D_P1   = 3'd1,
      D_P2   = 3'd2,
      D_M1   = 3'd3,
      D_M2   = 3'd4
   } booth_digit_t;

   // Radix-4 digits needed to cover a WIDTH operand extended by two bits
   function automatic int iter_count(input int width);
      return (width + 2) / 2;
   endfunction

endpackage

// File: rtl/booth_r4_mul_seq_if.sv
// rtl/booth_r4_mul_seq_if.sv - operand/product handshake bundle for the Booth multiplier
interface booth_r4_mul_seq_if #(
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   signed_mode;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     product;
   logic                   busy;

   modport master (
      output in_valid, multiplicand, multiplier, signed_mode, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, multiplicand, multiplier, signed_mode, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/booth_r4_recoder.sv
// rtl/booth_r4_recoder.sv - radix-4 Booth digit recoder and addend former
module booth_r4_recoder
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       window,
   input  logic [WIDTH+1:0] mx,
   output booth_digit_t     digit,
   output logic [WIDTH+2:0] addend,
   output logic             cin
);

   logic [WIDTH+2:0] m1;
   logic [WIDTH+2:0] m2;

   assign m1 = {mx[WIDTH+1], mx};
   assign m2 = {mx, 1'b0};

   // Map the {q1,q0,q-1} window onto a signed digit in -2..+2
   always_comb begin
      digit = D_ZERO;
      case (window)
         3'b001, 3'b010: digit = D_P1;
         3'b011:         digit = D_P2;
         3'b100:         digit = D_M2;
         3'b101, 3'b110: digit = D_M1;
         default:        digit = D_ZERO;
      endcase
   end

   // Negative digits use the inverted operand; the +1 enters as carry-in of the adder
   always_comb begin
      addend = '0;
      cin    = 1'b0;
      case (digit)
         D_P1: addend = m1;
         D_P2: addend = m2;
         D_M1: begin
            addend = ~m1;
            cin    = 1'b1;
         end
         D_M2: begin
            addend = ~m2;
            cin    = 1'b1;
         end
         default: begin
            addend = '0;
            cin    = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/booth_r4_mul_seq.sv
// rtl/booth_r4_mul_seq.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_r4_mul_seq
   import booth_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_r4_mul_seq_if.slave  bus
);

   localparam int ITER  = iter_count(WIDTH);
   localparam int CNT_W = $clog2(ITER + 1);
   localparam int AW    = WIDTH + 3;
   localparam int QW    = WIDTH + 2;

   if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("booth_r4_mul_seq: WIDTH must be even and >= 4");
   end

   state_t             state_q, state_d;
   logic [AW-1:0]      a_q, a_d;
   logic [QW-1:0]      qx_q, qx_d;
   logic               qm_q, qm_d;
   logic [QW-1:0]      mx_q, mx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   booth_digit_t       digit;
   logic [AW-1:0]      addend;
   logic               cin;
   logic [AW-1:0]      sum;
   logic [AW+QW:0]     combined;
   logic [AW+QW:0]     shifted;

   booth_r4_recoder #(.WIDTH(WIDTH)) u_recoder (
      .window (qx_q[1:0] == 2'b00 ? {2'b00, qm_q} : {qx_q[1:0], qm_q}),
      .mx     (mx_q),
      .digit  (digit),
      .addend (addend),
      .cin    (cin)
   );

   // Widen an operand by two bits, honouring the signedness chosen at accept
   function automatic logic [QW-1:0] extend(input logic [WIDTH-1:0] v, input logic sm);
      return {{2{sm & v[WIDTH-1]}}, v};
   endfunction

   // Add the recoded partial product, then arithmetic-shift {A,Qx,qm} right by two
   always_comb begin
      sum      = (digit == D_ZERO) ? a_q : (a_q + addend + {{(AW-1){1'b0}}, cin});
      combined = {sum, qx_q, qm_q};
      shifted  = {{2{sum[AW-1]}}, combined[AW+QW:2]};
   end

   // FSM and datapath next-state
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      qx_d      = qx_q;
      qm_d      = qm_q;
      mx_d      = mx_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mx_d    = extend(bus.multiplicand, bus.signed_mode);
               qx_d    = extend(bus.multiplier, bus.signed_mode);
               a_d     = '0;
               qm_d    = 1'b0;
               cnt_d   = '0;
               state_d = CALC;
            end
         end
         CALC: begin
            a_d   = shifted[AW+QW:QW+1];
            qx_d  = shifted[QW:1];
            qm_d  = shifted[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ITER - 1)) begin
               // Low 2*WIDTH bits of {A,Qx} after the last shift are the exact product
               product_d = shifted[2*WIDTH:1];
               state_d   = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         qx_q      <= '0;
         qm_q      <= 1'b0;
         mx_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         qx_q      <= qx_d;
         qm_q      <= qm_d;
         mx_q      <= mx_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.product   = product_q;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// tb/tb_booth_r4_mul_seq.sv - self-checking bench for booth_r4_mul_seq (WIDTH 8 and 16)
module tb_booth_r4_mul_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   booth_r4_mul_seq_if #(.WIDTH(8))  if8 ();
   booth_r4_mul_seq_if #(.WIDTH(16)) if16 ();

   booth_r4_mul_seq #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   booth_r4_mul_seq #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   int n_vec = 0;
   int n_err = 0;
   logic [15:0] sb8[$];
   logic [31:0] sb16[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref16(input logic [15:0] m, input logic [15:0] q, input bit sm);
      longint a, b;
      a = sm ? longint'($signed(m)) : longint'(m);
      b = sm ? longint'($signed(q)) : longint'(q);
      return 32'(a * b);
   endfunction

   task automatic op8(input logic [7:0] m, input logic [7:0] q, input bit sm,
                      input logic [15:0] exp, input int hold, input string tag);
      int lat;
      logic [15:0] held;
      logic [15:0] want;
      if8.multiplicand = m;
      if8.multiplier   = q;
      if8.signed_mode  = sm;
      if8.in_valid     = 1'b1;
      if8.out_ready    = (hold == 0);
      chk({tag, " in_ready_idle"}, 64'(if8.in_ready), 64'd1);
      tick();
      if8.in_valid = 1'b0;
      sb8.push_back(exp);
      lat = 0;
      while (!if8.out_valid && lat < 20) begin
         chk({tag, " in_ready_calc"}, 64'(if8.in_ready), 64'd0);
         chk({tag, " busy_calc"}, 64'(if8.busy), 64'd1);
         if8.multiplicand = 8'($urandom);
         if8.multiplier   = 8'($urandom);
         if8.signed_mode  = 1'($urandom);
         tick();
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd5);
      held = if8.product;
      for (int i = 0; i < hold; i++) begin
         if8.in_valid     = 1'b1;
         if8.multiplicand = 8'($urandom);
         tick();
         chk({tag, " hold_valid"}, 64'(if8.out_valid), 64'd1);
         chk({tag, " hold_product"}, 64'(if8.product), 64'(held));
         chk({tag, " hold_in_ready"}, 64'(if8.in_ready), 64'd0);
      end
      if8.in_valid  = 1'b0;
      if8.out_ready = 1'b1;
      if (sb8.size() == 0) begin
         chk({tag, " scoreboard_empty"}, 64'd0, 64'd1);
      end else begin
         want = sb8.pop_front();
         chk({tag, " product"}, 64'(if8.product), 64'(want));
      end
      tick();
      chk({tag, " valid_drop"}, 64'(if8.out_valid), 64'd0);
      chk({tag, " in_ready_back"}, 64'(if8.in_ready), 64'd1);
   endtask

   initial begin
      int lat;
      int hold;
      logic [15:0] m16, q16;
      bit sm16;
      logic [31:0] want16;

      if8.in_valid = 1'b0;  if8.out_ready = 1'b1;  if8.signed_mode = 1'b0;
      if8.multiplicand = '0; if8.multiplier = '0;
      if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.signed_mode = 1'b0;
      if16.multiplicand = '0; if16.multiplier = '0;

      rst_n = 1'b0;
      tick(); tick();
      chk("rst in_ready", 64'(if8.in_ready), 64'd1);
      chk("rst out_valid", 64'(if8.out_valid), 64'd0);
      chk("rst busy", 64'(if8.busy), 64'd0);
      chk("rst product", 64'(if8.product), 64'd0);
      chk("rst16 in_ready", 64'(if16.in_ready), 64'd1);
      chk("rst16 product", 64'(if16.product), 64'd0);
      rst_n = 1'b1;
      tick();

      op8(8'hFD, 8'h07, 1'b1, 16'hFFEB, 0, "s_m3x7");
      op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0, "u_ffxff");
      op8(8'hFF, 8'hFF, 1'b1, 16'h0001, 0, "s_ffxff");
      op8(8'h80, 8'h80, 1'b1, 16'h4000, 0, "s_min_min");
      op8(8'h80, 8'h7F, 1'b1, 16'hC080, 0, "s_min_max");
      op8(8'h5A, 8'h00, 1'b1, 16'h0000, 0, "s_q_zero");
      op8(8'h12, 8'h34, 1'b0, 16'h03A8, 10, "backpressure");
      op8(8'h0B, 8'h0D, 1'b0, 16'h008F, 0, "after_bp");

      // Abort an in-flight multiply with reset after two iterations
      if8.multiplicand = 8'h33; if8.multiplier = 8'h44; if8.signed_mode = 1'b0;
      if8.in_valid = 1'b1;
      tick();
      if8.in_valid = 1'b0;
      tick(); tick();
      rst_n = 1'b0;
      tick();
      chk("midrst out_valid", 64'(if8.out_valid), 64'd0);
      chk("midrst product", 64'(if8.product), 64'd0);
      chk("midrst in_ready", 64'(if8.in_ready), 64'd1);
      chk("midrst busy", 64'(if8.busy), 64'd0);
      rst_n = 1'b1;
      tick();
      op8(8'hFB, 8'hFA, 1'b1, 16'h001E, 0, "post_rst");

      // WIDTH=16 random traffic with idle gaps and consumer stalls
      for (int i = 0; i < 500; i++) begin
         repeat ($urandom_range(0, 3)) tick();
         m16  = 16'($urandom);
         q16  = 16'($urandom);
         sm16 = 1'($urandom_range(0, 1));
         if (i == 0) begin m16 = 16'h8000; q16 = 16'h8000; sm16 = 1'b1; end
         if (i == 1) begin m16 = 16'hFFFF; q16 = 16'hFFFF; sm16 = 1'b0; end
         if16.multiplicand = m16;
         if16.multiplier   = q16;
         if16.signed_mode  = sm16;
         if16.in_valid     = 1'b1;
         if16.out_ready    = 1'b0;
         chk("r16 in_ready", 64'(if16.in_ready), 64'd1);
         tick();
         if16.in_valid = 1'b0;
         sb16.push_back(ref16(m16, q16, sm16));
         lat = 0;
         while (!if16.out_valid && lat < 30) begin
            if16.multiplicand = 16'($urandom);
            if16.in_valid     = 1'($urandom);
            tick();
            lat++;
         end
         if16.in_valid = 1'b0;
         chk("r16 latency", 64'(lat), 64'd9);
         hold = $urandom_range(0, 3);
         repeat (hold) tick();
         if (sb16.size() == 0) begin
            chk("r16 scoreboard_empty", 64'd0, 64'd1);
         end else begin
            want16 = sb16.pop_front();
            chk("r16 product", 64'(if16.product), 64'(want16));
         end
         if16.out_ready = 1'b1;
         tick();
         if16.out_ready = 1'b0;
         chk("r16 valid_drop", 64'(if16.out_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
